// File: rtl/nibble_serial_sub.sv
// Digit-serial subtractor: Z = X - Y, one DIGIT-bit slice per clock, LSB first,
// with borrow/sign/overflow/parity/zero flags. Define NIBBLE_SUB_SATURATE_EN for saturation.
module nibble_serial_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z,
    output logic             borrow,
    output logic             sign,
    output logic             overflow,
    output logic             parity,
    output logic             zero
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_ny;
    logic [WIDTH-1:0] r_z;
    logic             r_carry;
    logic [KW-1:0]    r_k;
    logic             r_borrow;
    logic             r_sign;
    logic             r_overflow;
    logic             r_parity;
    logic             r_zero;

    logic [DIGIT:0]   w_sum;
    logic [WIDTH-1:0] w_z_next;
    logic [WIDTH-1:0] w_z_final;
    logic             w_last;
    logic             w_accept;
    logic             w_ovf;

    assign w_last   = (r_k == KW'(NSLICE - 1));
    assign w_accept = start && (r_state != S_RUN);

    // Single shared slice adder; r_ny holds ~Y so the carry preset supplies the +1.
    always_comb begin
        w_sum    = {1'b0, r_x[r_k*DIGIT +: DIGIT]}
                 + {1'b0, r_ny[r_k*DIGIT +: DIGIT]}
                 + {{DIGIT{1'b0}}, r_carry};
        w_z_next = r_z;
        w_z_next[r_k*DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
    end

    assign w_ovf = (r_x[MSB] & r_ny[MSB] & ~w_z_next[MSB])
                 | (~r_x[MSB] & ~r_ny[MSB] & w_z_next[MSB]);

`ifdef NIBBLE_SUB_SATURATE_EN
    always_comb begin
        w_z_final = w_z_next;
        if (w_last && w_ovf) begin
            w_z_final = r_x[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_z_final = w_z_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= '0;
            r_ny       <= '0;
            r_z        <= '0;
            r_carry    <= 1'b0;
            r_k        <= '0;
            r_borrow   <= 1'b0;
            r_sign     <= 1'b0;
            r_overflow <= 1'b0;
            r_parity   <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            r_x     <= X;
            r_ny    <= ~Y;
            r_carry <= 1'b1;
            r_k     <= '0;
        end else if (r_state == S_RUN) begin
            r_z     <= w_z_final;
            r_carry <= w_sum[DIGIT];
            r_k     <= r_k + 1'b1;
            // Flags only move on the final slice so they hold through the next run.
            if (w_last) begin
                r_borrow   <= ~w_sum[DIGIT];
                r_sign     <= w_z_final[MSB];
                r_overflow <= w_ovf;
                r_parity   <= ~^w_z_final;
                r_zero     <= (w_z_final == '0);
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign Z        = r_z;
    assign borrow   = r_borrow;
    assign sign     = r_sign;
    assign overflow = r_overflow;
    assign parity   = r_parity;
    assign zero     = r_zero;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed self-checking bench for nibble_serial_sub (WIDTH=16, DIGIT=4).
// Flag vectors are packed {borrow, sign, overflow, parity, zero}.
module tb_nibble_serial_sub;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] X;
    logic [15:0] Y;
    logic        busy;
    logic        done;
    logic [15:0] Z;
    logic        borrow;
    logic        sign;
    logic        overflow;
    logic        parity;
    logic        zero;

    int errors;
    int checks;

    nibble_serial_sub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .X        (X),
        .Y        (Y),
        .busy     (busy),
        .done     (done),
        .Z        (Z),
        .borrow   (borrow),
        .sign     (sign),
        .overflow (overflow),
        .parity   (parity),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; X = '0; Y = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/done %b expected 00", {busy, done});
        end
        checks++;
        if ({Z, borrow, sign, overflow, parity, zero} !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs: got Z=%h flags=%b expected 0", Z,
                     {borrow, sign, overflow, parity, zero});
        end
    endtask

    task automatic test_arith;
        logic [15:0] vx [5];
        logic [15:0] vy [5];
        logic [15:0] vz [5];
        logic [4:0]  vf [5];
        int n;
        vx[0] = 16'h0005; vy[0] = 16'h0003; vz[0] = 16'h0002; vf[0] = 5'b00000;
        vx[1] = 16'h0003; vy[1] = 16'h0005; vz[1] = 16'hFFFE; vf[1] = 5'b11000;
        vx[2] = 16'h1234; vy[2] = 16'h1234; vz[2] = 16'h0000; vf[2] = 5'b00011;
`ifdef NIBBLE_SUB_SATURATE_EN
        vx[3] = 16'h8000; vy[3] = 16'h0001; vz[3] = 16'h8000; vf[3] = 5'b01100;
        vx[4] = 16'h7FFF; vy[4] = 16'hFFFF; vz[4] = 16'h7FFF; vf[4] = 5'b10100;
`else
        vx[3] = 16'h8000; vy[3] = 16'h0001; vz[3] = 16'h7FFF; vf[3] = 5'b00100;
        vx[4] = 16'h7FFF; vy[4] = 16'hFFFF; vz[4] = 16'h8000; vf[4] = 5'b11100;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            X = vx[i]; Y = vy[i]; start = 1'b1;
            @(negedge clk);
            start = 1'b0; X = 16'hAAAA; Y = 16'h5555;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_accept vec%0d: got %b expected 1", i, busy);
            end
            n = 1;
            while (done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n !== 5) begin
                errors++;
                $display("FAIL latency vec%0d: got %0d cycles expected 5", i, n);
            end
            checks++;
            if (Z !== vz[i]) begin
                errors++;
                $display("FAIL z vec%0d: got %h expected %h", i, Z, vz[i]);
            end
            checks++;
            if ({borrow, sign, overflow, parity, zero} !== vf[i]) begin
                errors++;
                $display("FAIL flags vec%0d: got %b expected %b", i,
                         {borrow, sign, overflow, parity, zero}, vf[i]);
            end
            @(negedge clk);
            checks++;
            if ({done, busy} !== 2'b00 || Z !== vz[i]) begin
                errors++;
                $display("FAIL hold vec%0d: got done/busy=%b Z=%h expected 00 %h", i,
                         {done, busy}, Z, vz[i]);
            end
        end
    endtask

    task automatic test_ignored_start;
        int n;
        @(negedge clk);
        X = 16'h0100; Y = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        X = 16'hFFFF; Y = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 3;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL ignored_latency: got %0d cycles expected 5", n);
        end
        checks++;
        if (Z !== 16'h00FF || {borrow, sign, overflow, parity, zero} !== 5'b00010) begin
            errors++;
            $display("FAIL ignored_result: got Z=%h flags=%b expected 00ff 00010", Z,
                     {borrow, sign, overflow, parity, zero});
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ignored_no_restart: got done/busy=%b expected 00", {done, busy});
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        X = 16'h1234; Y = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (Z[3:0] !== 4'h3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_partial: got Z=%h busy=%b expected slice0=3 busy=1", Z, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, Z, borrow, sign, overflow, parity, zero} !== 23'h0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b done=%b Z=%h flags=%b expected all 0",
                     busy, done, Z, {borrow, sign, overflow, parity, zero});
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        X = 16'h0010; Y = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 5 || Z !== 16'h000F || {borrow, sign, overflow, parity, zero} !== 5'b00010) begin
            errors++;
            $display("FAIL b2b_first: got n=%0d Z=%h flags=%b expected 5 000f 00010", n, Z,
                     {borrow, sign, overflow, parity, zero});
        end
        X = 16'h0000; Y = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b01 || Z !== 16'h000F) begin
            errors++;
            $display("FAIL b2b_accept: got done/busy=%b Z=%h expected 01 000f", {done, busy}, Z);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (Z !== 16'h00FF || {borrow, sign, overflow, parity, zero} !== 5'b00010) begin
            errors++;
            $display("FAIL b2b_midrun: got Z=%h flags=%b expected 00ff 00010", Z,
                     {borrow, sign, overflow, parity, zero});
        end
        n = 3;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL b2b_latency: got %0d cycles expected 5", n);
        end
        checks++;
        if (Z !== 16'hFFFF || {borrow, sign, overflow, parity, zero} !== 5'b11010) begin
            errors++;
            $display("FAIL b2b_second: got Z=%h flags=%b expected ffff 11010", Z,
                     {borrow, sign, overflow, parity, zero});
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset;
        test_arith;
        test_ignored_start;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
- Sequential counterpart to the combinational nibble-sliced adder datapath.
- Computes Z = X − Y one DIGIT-bit slice per clock, LSB slice first, by reusing a single DIGIT-bit adder slice.
- Produces the same flag set as the adder: borrow (in place of carry), sign, overflow, parity, zero.
- Sits beside the ALU for area-constrained subtract paths and uses a start/busy/done handshake.

Parameters:
- WIDTH, 16: operand and result width. Must be a multiple of DIGIT.
- DIGIT, 4: slice width processed per cycle. Latency = WIDTH/DIGIT cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only when not busy.
- X  input  WIDTH  minuend; sampled only on the accepting edge.
- Y  input  WIDTH  subtrahend; sampled only on the accepting edge.
- busy  output  1  high while slices are being processed.
- done  output  1  single-cycle pulse; results are valid from this cycle onward.
- Z  output  WIDTH  difference X − Y, two's complement.
- borrow  output  1  1 when unsigned X < Y (inverted carry-out of the MSB slice).
- sign  output  1  Z[WIDTH-1].
- overflow  output  1  signed overflow.
- parity  output  1  1 when Z has an even number of ones (XNOR-reduce of Z).
- zero  output  1  1 when Z == 0.

Behaviour:
- Reset: rst sampled high at an edge forces state IDLE. Z, borrow, sign, overflow, parity, zero, busy and done all go to 0. This applies mid-operation too; the partial result is discarded.
- States:
  - IDLE: no operation in progress.
  - RUN: slice counter k counts 0..WIDTH/DIGIT−1.
  - DONE: one cycle long.
- Accept: at an edge where start=1 and state is IDLE or DONE:
  - Latch X and ~Y into operand registers.
  - Preset the internal carry register to 1 (two's complement +1).
  - Set k=0 and enter RUN; busy=1 from the next cycle.
- RUN, each edge:
  - Slice sum = X[k] + ~Y[k] + carry.
  - Write the sum to Z slice k and the carry-out to the carry register; k increments.
  - Only slice k of Z changes that edge.
- Last slice edge:
  - Transition to DONE; busy=0 and done=1 in the following cycle.
  - borrow = ~final carry.
  - sign, parity and zero are computed from the complete Z.
  - overflow = (X_msb & ~Y_msb & ~Z_msb) | (~X_msb & Y_msb & Z_msb), using the latched operands.
- Timing: start accepted at edge N → done high in the cycle after edge N+WIDTH/DIGIT (N+4 at default). One operation every 5 cycles in steady state.
- Result hold: flags and Z are valid from the done cycle and held stable until the next accept. Z updates slice-by-slice during a new run; flags hold their old values until that run's DONE.
- Back-to-back: start accepted in the DONE cycle begins the next operation immediately; done deasserts next cycle.
- Ignored start: start while busy is ignored, with no effect on the operation in progress.
- Accept edge: a start coincident with the accept edge's own done is covered by the back-to-back rule.
- Simultaneous events: rst wins over start.
- Arithmetic: all arithmetic is modulo 2^WIDTH. There is no signed/unsigned mode; borrow gives the unsigned view and overflow gives the signed view.

Optional Feature:
- Macro: NIBBLE_SUB_SATURATE_EN.
- Defined: when overflow is detected at the final slice, Z is replaced in the DONE transition by the saturated value.
  - 0x7FFF (generalised: 0 followed by ones) if X_msb=0.
  - 0x8000 (1 followed by zeros) if X_msb=1.
  - sign, parity and zero are computed from the saturated Z.
  - overflow still reports 1; borrow is unchanged.
- Undefined: Z wraps modulo 2^WIDTH and no saturation logic is present.

Test Plan:
- X=0x0005, Y=0x0003, start at edge N → done after edge N+4; Z=0x0002, borrow=0, sign=0, overflow=0, zero=0, parity=0.
- X=0x0003, Y=0x0005 → Z=0xFFFE, borrow=1, sign=1, overflow=0, zero=0, parity=0.
- X=0x8000, Y=0x0001:
  - Without macro: Z=0x7FFF, overflow=1, sign=0, borrow=0, parity=0.
  - With NIBBLE_SUB_SATURATE_EN: Z=0x8000, overflow=1, sign=1, parity=0.
- X=0x1234, Y=0x1234 → Z=0x0000, zero=1, parity=1, borrow=0, overflow=0.
- Start X=0x0100, Y=0x0001; pulse start again with X=0xFFFF, Y=0 at edge N+2 → ignored; result Z=0x00FF, parity=1. Then assert rst at edge N+2 of a fresh run → busy=0, done never pulses, all outputs 0.
- Start X=0x0010, Y=0x0001, then assert start in its done cycle with X=0x0000, Y=0x0001:
  - First result Z=0x000F, held through the done cycle.
  - Second done arrives 4 cycles later with Z=0xFFFF, borrow=1, sign=1, parity=1.
